// File: rtl/wim_seg_encoder_if.sv
// Request/response bus for the segment-pattern encoder: a pattern goes in and a code/hit result comes back,
// each on its own valid/ready handshake.
interface wim_seg_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_pattern;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_code;
  logic       out_hit;

  modport master (
    output in_valid, in_pattern, out_ready,
    input  in_ready, out_valid, out_code, out_hit
  );

  modport slave (
    input  in_valid, in_pattern, out_ready,
    output in_ready, out_valid, out_code, out_hit
  );
endinterface

// File: rtl/wim_seg_encoder.sv
// Sequential inverse of the wim 4-to-7 segment decode: it scans candidate codes in ascending order, one per
// cycle, and returns the first code whose decoded pattern equals the latched input pattern.
//
// state  | meaning
// IDLE   | in_ready high; waiting for a pattern
// SEARCH | comparing decode(cand) against the latched pattern, one candidate per cycle
// DONE   | result held on out_code/out_hit with out_valid high until out_ready
module wim_seg_encoder #(
  parameter int MAX_CODE = 15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  wim_seg_encoder_if.slave     bus,
  output logic                 o_busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] LP_MAX_CODE = 4'(MAX_CODE);

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h6F;
      4'd1:    seg = 7'h24;
      4'd2:    seg = 7'h5D;
      4'd3:    seg = 7'h75;
      4'd4:    seg = 7'h37;
      4'd5:    seg = 7'h73;
      4'd6:    seg = 7'h7B;
      4'd7:    seg = 7'h35;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h77;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [1:0] r_state;
  logic [3:0] r_cand;
  logic [6:0] r_pattern;
  logic [3:0] r_code;
  logic       r_hit;

  logic [6:0] w_cand_seg;
  logic       w_match;
  logic       w_last;

  assign w_cand_seg = seg_decode(r_cand);
  assign w_match    = (w_cand_seg == r_pattern);
  // The terminal compare stops the scan before the 4-bit candidate can wrap past 15.
  assign w_last     = (r_cand == LP_MAX_CODE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cand    <= 4'd0;
      r_pattern <= 7'd0;
      r_code    <= 4'd0;
      r_hit     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_pattern <= bus.in_pattern;
            r_cand    <= 4'd0;
            r_state   <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (w_match) begin
            r_code  <= r_cand;
            r_hit   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_last) begin
            r_code  <= 4'd0;
            r_hit   <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_cand <= r_cand + 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All handshake outputs decode from registered state only, so no input reaches an output combinationally.
  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_code  = r_code;
  assign bus.out_hit   = r_hit;
  assign o_busy        = (r_state == ST_SEARCH);

endmodule

// File: tb/tb_wim_seg_encoder.sv
// Self-checking bench for wim_seg_encoder: directed steps plus random patterns, checked against a table-scan
// model, on one instance with MAX_CODE=15 and one with MAX_CODE=9.
module tb_wim_seg_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy15, busy9;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wim_seg_encoder_if bus15();
  wim_seg_encoder_if bus9();

  wim_seg_encoder #(.MAX_CODE(15)) dut15 (
    .i_clk(clk), .i_reset(reset), .bus(bus15.slave), .o_busy(busy15)
  );
  wim_seg_encoder #(.MAX_CODE(9)) dut9 (
    .i_clk(clk), .i_reset(reset), .bus(bus9.slave), .o_busy(busy9)
  );

  logic [6:0] seg_tab [16] = '{7'h6F, 7'h24, 7'h5D, 7'h75, 7'h37, 7'h73, 7'h7B, 7'h35,
                               7'h7F, 7'h77, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First matching code in ascending scan, or a miss after MAX_CODE+1 compares.
  task automatic model(input logic [6:0] pat, input int maxc, output logic hit,
                       output logic [3:0] code, output int lat);
    hit  = 1'b0;
    code = 4'd0;
    lat  = maxc + 2;
    for (int k = 0; k <= maxc; k++) begin
      if (seg_tab[k] == pat) begin
        hit  = 1'b1;
        code = 4'(k);
        lat  = k + 2;
        break;
      end
    end
  endtask

  task automatic sample(input bit sel9, output logic ov, output logic ir, output logic bz,
                        output logic [3:0] code, output logic hit);
    if (sel9) begin
      ov = bus9.out_valid; ir = bus9.in_ready; bz = busy9; code = bus9.out_code; hit = bus9.out_hit;
    end else begin
      ov = bus15.out_valid; ir = bus15.in_ready; bz = busy15; code = bus15.out_code; hit = bus15.out_hit;
    end
  endtask

  task automatic set_in(input bit sel9, input logic iv, input logic [6:0] pat);
    if (sel9) begin
      bus9.in_valid = iv; bus9.in_pattern = pat;
    end else begin
      bus15.in_valid = iv; bus15.in_pattern = pat;
    end
  endtask

  task automatic do_req(input bit sel9, input logic [6:0] pat, input string tag);
    logic ov, ir, bz, hit, ehit;
    logic [3:0] code, ecode;
    int elat, cyc, busy_cyc, ir_hi, waitc;
    model(pat, sel9 ? 9 : 15, ehit, ecode, elat);
    @(negedge clk);
    sample(sel9, ov, ir, bz, code, hit);
    waitc = 0;
    while (!ir && waitc < 20) begin
      @(negedge clk);
      sample(sel9, ov, ir, bz, code, hit);
      waitc++;
    end
    chk($sformatf("%s_pre_in_ready", tag), 32'(ir), 32'd1);
    set_in(sel9, 1'b1, pat);
    @(negedge clk);
    set_in(sel9, 1'b0, 7'($urandom));
    cyc = 1; busy_cyc = 0; ir_hi = 0;
    sample(sel9, ov, ir, bz, code, hit);
    while (!ov && cyc < 40) begin
      if (bz) busy_cyc++;
      if (ir) ir_hi++;
      @(negedge clk);
      cyc++;
      sample(sel9, ov, ir, bz, code, hit);
    end
    chk($sformatf("%s_latency pat=%0h", tag, pat), 32'(cyc), 32'(elat));
    chk($sformatf("%s_code pat=%0h", tag, pat), 32'(code), 32'(ecode));
    chk($sformatf("%s_hit pat=%0h", tag, pat), 32'(hit), 32'(ehit));
    chk($sformatf("%s_busy_cycles", tag), 32'(busy_cyc), 32'(elat - 1));
    chk($sformatf("%s_in_ready_low", tag), 32'(ir_hi + (ir ? 1 : 0)), 32'd0);
    @(negedge clk);
    sample(sel9, ov, ir, bz, code, hit);
    chk($sformatf("%s_post_out_valid", tag), 32'(ov), 32'd0);
    chk($sformatf("%s_post_in_ready", tag), 32'(ir), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ov, ir, bz, hit;
    logic [3:0] code;
    int cyc, ov_seen;
    bit sel;
    logic [6:0] pat;

    bus15.in_valid = 1'b0; bus15.in_pattern = 7'd0; bus15.out_ready = 1'b1;
    bus9.in_valid  = 1'b0; bus9.in_pattern  = 7'd0; bus9.out_ready  = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s == 1, ov, ir, bz, code, hit);
      chk($sformatf("rst%0d_in_ready", s), 32'(ir), 32'd1);
      chk($sformatf("rst%0d_out_valid", s), 32'(ov), 32'd0);
      chk($sformatf("rst%0d_out_code", s), 32'(code), 32'd0);
      chk($sformatf("rst%0d_out_hit", s), 32'(hit), 32'd0);
      chk($sformatf("rst%0d_busy", s), 32'(bz), 32'd0);
    end
    reset = 1'b0;

    do_req(1'b0, 7'h6F, "first");
    for (int k = 0; k < 10; k++) do_req(1'b0, seg_tab[k], $sformatf("sweep%0d", k));
    do_req(1'b0, 7'h00, "zero_max15");
    do_req(1'b1, 7'h00, "zero_max9");
    do_req(1'b0, 7'h7E, "miss_max15");
    do_req(1'b1, 7'h7E, "miss_max9");

    // Backpressure: result must hold while in_valid/in_pattern toggle.
    bus15.out_ready = 1'b0;
    @(negedge clk);
    set_in(1'b0, 1'b1, seg_tab[3]);
    @(negedge clk);
    set_in(1'b0, 1'b0, 7'd0);
    cyc = 1;
    sample(1'b0, ov, ir, bz, code, hit);
    while (!ov && cyc < 40) begin
      @(negedge clk);
      cyc++;
      sample(1'b0, ov, ir, bz, code, hit);
    end
    chk("bp_latency", 32'(cyc), 32'd5);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, (i % 2) == 0, 7'($urandom));
      @(negedge clk);
      sample(1'b0, ov, ir, bz, code, hit);
      chk($sformatf("bp_hold%0d_out_valid", i), 32'(ov), 32'd1);
      chk($sformatf("bp_hold%0d_code", i), 32'(code), 32'd3);
      chk($sformatf("bp_hold%0d_hit", i), 32'(hit), 32'd1);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(ir), 32'd0);
    end
    set_in(1'b0, 1'b0, 7'd0);
    bus15.out_ready = 1'b1;
    @(negedge clk);
    sample(1'b0, ov, ir, bz, code, hit);
    chk("bp_release_out_valid", 32'(ov), 32'd0);
    chk("bp_release_in_ready", 32'(ir), 32'd1);
    @(negedge clk);
    sample(1'b0, ov, ir, bz, code, hit);
    chk("bp_no_queued_accept", 32'(bz), 32'd0);

    // Reset while the candidate counter sits at 4 in a search for 0x35 (code 7).
    @(negedge clk);
    set_in(1'b0, 1'b1, 7'h35);
    @(negedge clk);
    set_in(1'b0, 1'b0, 7'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sample(1'b0, ov, ir, bz, code, hit);
    chk("midrst_out_valid", 32'(ov), 32'd0);
    chk("midrst_in_ready", 32'(ir), 32'd1);
    chk("midrst_busy", 32'(bz), 32'd0);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample(1'b0, ov, ir, bz, code, hit);
      if (ov) ov_seen++;
    end
    chk("midrst_result_discarded", 32'(ov_seen), 32'd0);
    do_req(1'b0, 7'h37, "after_rst");

    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) pat = seg_tab[$urandom_range(0, 15)];
      else pat = 7'($urandom);
      do_req(sel, pat, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wim_seg_encoder.md
# wim_seg_encoder

Sequential inverse of the `wim` 4-to-7 segment decode function. It accepts a 7-bit segment pattern over a valid/ready handshake and finds the 4-bit code that the decode function maps to that pattern. The search steps through candidate codes, one per cycle, in ascending order. The result is returned over a second valid/ready handshake; the block sits on the readback side of the display path.

## Interface
- `MAX_CODE`, default 15: highest candidate code searched; legal range 0..15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: `in_pattern` is valid.
- `in_ready` output 1: block can accept a pattern.
- `in_pattern` input 7: segment pattern; bit i corresponds to decode output zi.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: consumer accepts the result.
- `out_code` output 4: matched code (bit 3 = x0, bit 0 = x3).
- `out_hit` output 1: 1 = match found, 0 = no candidate matched.
- `busy` output 1: high in SEARCH state.

## Operation
- Decode function f(code) → pattern z6..z0, in hex:
  - 0:6F, 1:24, 2:5D, 3:75, 4:37
  - 5:73, 6:7B, 7:35, 8:7F, 9:77
  - 10–15: 00
- The block holds f as an internal constant function and evaluates f(cand) combinationally.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `in_pattern`, set cand = 0, go to SEARCH.
- SEARCH:
  - Each cycle, compare f(cand) with the latched pattern.
  - On a match, register `out_code` = cand and `out_hit` = 1, then go to DONE.
  - Else, if cand == `MAX_CODE`, register `out_code` = 0 and `out_hit` = 0, then go to DONE.
  - Otherwise cand increments by 1.
- Because candidates ascend, the first match wins. Pattern 00 returns code 10 (when `MAX_CODE` ≥ 10).
- DONE:
  - `out_valid` = 1; `out_code` and `out_hit` are held stable.
  - On `out_ready`, go to IDLE.
- cand is a 4-bit counter. It never wraps: SEARCH terminates at `MAX_CODE`, and `MAX_CODE` = 15 must not overflow into a 16th compare.
- `in_pattern` is ignored outside IDLE. `in_valid` held high during SEARCH/DONE does not queue a second request.

## Timing
- Reset values:
  - state = IDLE, `in_ready` = 1.
  - `out_valid` = 0, `out_code` = 0, `out_hit` = 0, `busy` = 0.
  - cand = 0; latched pattern = 0.
- Reset asserted mid-SEARCH or in DONE:
  - The next edge forces IDLE and the reset values above.
  - An in-flight result is discarded, never emitted.
- Latency: accept edge at cycle T; a match at code k sets `out_valid` = 1 in cycle T+k+2, visible after k+1 further edges.
- A miss sets `out_valid` in cycle T+`MAX_CODE`+2.
- `out_valid` remains 1 until the edge where `out_ready` = 1, then drops. `in_ready` rises in that same following cycle.
- There is no combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.
- Throughput: one request per (search length + 2) cycles minimum, given `out_ready` = 1.
- `out_ready` high before `out_valid` has no effect.

## Test plan
- Reset, then `in_pattern` = 0x6F with `in_valid` pulse:
  - `out_code` = 0, `out_hit` = 1.
  - `out_valid` rises 2 cycles after the accept cycle.
  - `busy` is high for 1 cycle.
- Sweep codes 0..9: send f(k) for each, with `out_ready` tied 1.
  - `out_code` = k and `out_hit` = 1, latency k+2 cycles each.
  - `in_ready` is low from accept until the cycle after the handshake.
- `in_pattern` = 0x00:
  - `out_code` = 10, `out_hit` = 1, latency 12.
  - With `MAX_CODE` = 9: `out_hit` = 0, `out_code` = 0, latency 11.
- `in_pattern` = 0x7E (not in table):
  - `out_hit` = 0, `out_code` = 0, `out_valid` after 17 cycles.
  - cand stops at 15 with no wrap.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid`, while toggling `in_valid` and `in_pattern`.
  - Outputs stay stable and no new accept occurs.
  - Release `out_ready`: `out_valid` drops next cycle and `in_ready` = 1.
- Assert `reset` for 1 cycle while cand = 4 during a search for 0x35:
  - Next cycle state = IDLE, `out_valid` = 0, `in_ready` = 1.
  - The following 0x37 request returns code 4.
